stream_settings_bank: RTL and testbench
=======================================

Name: stream_settings_bank

Overview:
- Parametrised successor to the accelerator's global settings page.
- Adds registered read path with acknowledge, per-stream enable bits, sticky per-stream completion status (write-1-to-clear), interrupt mask/output, and a stretched, retriggerable soft reset with busy flag.
- Sits on the control-register page between the AXI-Lite slave (set/get strobes) and the S2H/H2S stream engines.

Parameters:
- C_DATAWIDTH, 32, register/data width.
- C_ADDRWIDTH, 32, address width.
- C_PAGEWIDTH, 12, page size in address bits; register index = addr[C_PAGEWIDTH-1:2].
- C_S2H_NUM_STREAMS, 2, number of S2H streams (NS).
- C_H2S_NUM_STREAMS, 2, number of H2S streams (NH); NS+NH <= C_DATAWIDTH.
- C_SOFT_RESET_CYCLES, 16, soft_reset pulse length in clocks, >= 1.
- C_SIGNATURE, 32'hace0ba54, value read at index 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- set_data  in  C_DATAWIDTH  write data.
- set_stb  in  1  write strobe, one cycle per write.
- set_addr  in  C_ADDRWIDTH  write byte address.
- get_stb  in  1  read strobe.
- get_addr  in  C_ADDRWIDTH  read byte address.
- get_data  out  C_DATAWIDTH  registered read data.
- get_ack  out  1  one-cycle pulse, get_data valid.
- s2h_done  in  NS  per-stream completion pulses.
- h2s_done  in  NH  per-stream completion pulses.
- soft_reset  out  1  registered soft reset to stream engines.
- aruser, arcache, awuser, awcache  out  C_DATAWIDTH each  AXI sideband values.
- s2h_en  out  NS  stream enables.
- h2s_en  out  NH  stream enables.
- irq  out  1  registered interrupt, level.

Behaviour:
- Unified bit layout (EN/STATUS/MASK): bits [NS-1:0] are S2H, bits [NS+NH-1:NS] are H2S; upper bits read 0 and ignore writes.
- Register map (index):
  - 0: W starts soft reset (data ignored); R returns C_SIGNATURE.
  - 1: aruser RW. 2: arcache RW. 3: awuser RW. 4: awcache RW.
  - 5: R returns NS. 6: R returns NH.
  - 7: EN RW. 8: STATUS R/W1C. 9: MASK RW.
  - 10: R, bit0 = soft_reset active.
  - Other indices: writes ignored; reads return 32'h01234567.
- Writes: register updates at the clock edge where set_stb is high; outputs are taken directly from the registers, so a new value is visible the next cycle. Writes to read-only indices have no effect.
- Reads: get_stb sampled at edge N; get_data and get_ack are valid after edge N (1-cycle latency). get_ack is high for exactly one cycle per get_stb, and back-to-back strobes give back-to-back acks. get_data holds its last value when get_ack is low. A read in the same cycle as a write to the same register returns the pre-write value.
- STATUS:
  - Bit sets when its done input is high at an edge.
  - A W1C write clears the bits written as 1.
  - Set and clear in the same cycle on the same bit: set wins (bit stays 1).
- irq: registered, = |(STATUS & MASK) from the previous cycle, so it asserts 2 edges after a done pulse.
- Soft reset:
  - Counter loads C_SOFT_RESET_CYCLES on a write to index 0; soft_reset = (counter != 0), registered.
  - Counter decrements each cycle; a write to index 0 while active reloads the counter (retrigger).
  - While soft_reset is high: EN and STATUS forced to 0, done inputs ignored, writes to EN/STATUS ignored.
  - aruser/arcache/awuser/awcache/MASK are unaffected by soft reset; reads operate normally.
- rst_n low at an edge:
  - All registers 0: aruser, arcache, awuser, awcache, EN, STATUS, MASK, counter.
  - soft_reset=0, irq=0, get_ack=0, get_data=0.
  - rst_n overrides any in-flight strobe, including a pending read ack and an active soft reset.

Test Plan:
- Reset, then read idx 0, 5, 6, 11 -> get_ack one cycle after each get_stb; data 0xace0ba54, 2, 2, 0x01234567; all outputs 0.
- Write 0xA5 to idx 1, then read it with get_stb on the next cycle -> aruser=0xA5 visible next cycle; read returns 0xA5. A read in the same cycle as the write returns 0.
- MASK=0x1, pulse s2h_done[0] -> STATUS=0x1 and irq high 2 edges later. Write STATUS 0x1 in the same cycle as a new s2h_done[0] -> bit stays 1. W1C alone -> STATUS=0, irq drops next cycle.
- EN=0xF, write idx 0 -> soft_reset high 16 cycles and EN reads 0. Rewrite idx 0 at cycle 10 -> high 26 cycles total; idx 10 reads 1 during the pulse, 0 after.
- Assert rst_n=0 mid-soft-reset and with a read pending -> soft_reset, get_ack, irq and all registers 0 on the next edge.

Source files
------------

// File: rtl/stream_settings_bank.sv
// stream_settings_bank
//   Control-register page between the AXI-Lite set/get strobes and the
//   S2H/H2S stream engines. It holds the AXI sideband values, per-stream
//   enables, sticky write-1-to-clear completion status with an interrupt
//   mask, and a stretched, retriggerable soft reset.
//
// Ports
//   clk, rst_n                clock, synchronous active-low reset
//   set_stb/set_addr/set_data one-cycle write strobe, byte address, data
//   get_stb/get_addr          read strobe and byte address
//   get_data/get_ack          registered read data and one-cycle acknowledge
//   s2h_done/h2s_done         per-stream completion pulses
//   soft_reset                registered soft reset to the stream engines
//   aruser/arcache/awuser/awcache  AXI sideband values
//   s2h_en/h2s_en             per-stream enables
//   irq                       registered level interrupt
//
// Index map: 0 sig/soft-reset, 1-4 sideband, 5 NS, 6 NH, 7 EN,
// 8 STATUS (W1C), 9 MASK, 10 soft-reset busy.
module stream_settings_bank #(
    parameter int                     C_DATAWIDTH         = 32,
    parameter int                     C_ADDRWIDTH         = 32,
    parameter int                     C_PAGEWIDTH         = 12,
    parameter int                     C_S2H_NUM_STREAMS   = 2,
    parameter int                     C_H2S_NUM_STREAMS   = 2,
    parameter int                     C_SOFT_RESET_CYCLES = 16,
    parameter logic [C_DATAWIDTH-1:0] C_SIGNATURE         = 32'hace0ba54
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [C_DATAWIDTH-1:0]       set_data,
    input  logic                         set_stb,
    input  logic [C_ADDRWIDTH-1:0]       set_addr,
    input  logic                         get_stb,
    input  logic [C_ADDRWIDTH-1:0]       get_addr,
    output logic [C_DATAWIDTH-1:0]       get_data,
    output logic                         get_ack,
    input  logic [C_S2H_NUM_STREAMS-1:0] s2h_done,
    input  logic [C_H2S_NUM_STREAMS-1:0] h2s_done,
    output logic                         soft_reset,
    output logic [C_DATAWIDTH-1:0]       aruser,
    output logic [C_DATAWIDTH-1:0]       arcache,
    output logic [C_DATAWIDTH-1:0]       awuser,
    output logic [C_DATAWIDTH-1:0]       awcache,
    output logic [C_S2H_NUM_STREAMS-1:0] s2h_en,
    output logic [C_H2S_NUM_STREAMS-1:0] h2s_en,
    output logic                         irq
);

    localparam int NS = C_S2H_NUM_STREAMS;
    localparam int NB = C_S2H_NUM_STREAMS + C_H2S_NUM_STREAMS;
    localparam int IW = C_PAGEWIDTH - 2;
    localparam int CW = $clog2(C_SOFT_RESET_CYCLES + 1);

    logic [C_DATAWIDTH-1:0] r_aruser, r_arcache, r_awuser, r_awcache;
    logic [C_DATAWIDTH-1:0] r_get_data;
    logic                   r_get_ack;
    logic [NB-1:0]          r_en, r_status, r_mask;
    logic [CW-1:0]          r_cnt;
    logic                   r_soft_reset;
    logic                   r_irq;

    logic [IW-1:0]          w_set_idx, w_get_idx;
    logic                   w_wr_reset;
    logic                   w_busy;
    logic [CW-1:0]          w_cnt_next;
    logic [NB-1:0]          w_done, w_clr, w_en_next, w_status_next;
    logic [C_DATAWIDTH-1:0] w_rdata;
    logic                   w_unused_addr;

    assign w_set_idx = set_addr[C_PAGEWIDTH-1:2];
    assign w_get_idx = get_addr[C_PAGEWIDTH-1:2];

    // Address bits outside the page index do not take part in decode.
    assign w_unused_addr = ^{set_addr[C_ADDRWIDTH-1:C_PAGEWIDTH], set_addr[1:0],
                             get_addr[C_ADDRWIDTH-1:C_PAGEWIDTH], get_addr[1:0]};

    assign w_wr_reset = set_stb && (w_set_idx == IW'(0));
    assign w_cnt_next = w_wr_reset        ? CW'(C_SOFT_RESET_CYCLES) :
                        (r_cnt != '0)     ? r_cnt - CW'(1) : '0;

    // Blanking covers the write edge that starts the pulse as well as the
    // cycles in which soft_reset is already high.
    assign w_busy = r_soft_reset || w_wr_reset;

    assign w_done = {h2s_done, s2h_done};
    assign w_clr  = (set_stb && (w_set_idx == IW'(8))) ? set_data[NB-1:0] : '0;

    // A done pulse on the same edge as a W1C of that bit keeps the bit set.
    assign w_status_next = w_busy ? '0 : ((r_status & ~w_clr) | w_done);
    assign w_en_next     = w_busy ? '0 :
                           (set_stb && (w_set_idx == IW'(7))) ? set_data[NB-1:0] : r_en;

    always_comb begin
        w_rdata = C_DATAWIDTH'(32'h01234567);
        case (w_get_idx)
            IW'(0):  w_rdata = C_SIGNATURE;
            IW'(1):  w_rdata = r_aruser;
            IW'(2):  w_rdata = r_arcache;
            IW'(3):  w_rdata = r_awuser;
            IW'(4):  w_rdata = r_awcache;
            IW'(5):  w_rdata = C_DATAWIDTH'(C_S2H_NUM_STREAMS);
            IW'(6):  w_rdata = C_DATAWIDTH'(C_H2S_NUM_STREAMS);
            IW'(7):  w_rdata = C_DATAWIDTH'(r_en);
            IW'(8):  w_rdata = C_DATAWIDTH'(r_status);
            IW'(9):  w_rdata = C_DATAWIDTH'(r_mask);
            IW'(10): w_rdata = C_DATAWIDTH'(r_soft_reset);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aruser     <= '0;
            r_arcache    <= '0;
            r_awuser     <= '0;
            r_awcache    <= '0;
            r_en         <= '0;
            r_status     <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
            r_irq        <= 1'b0;
            r_get_ack    <= 1'b0;
            r_get_data   <= '0;
        end else begin
            r_get_ack <= get_stb;
            if (get_stb) r_get_data <= w_rdata;

            if (set_stb) begin
                case (w_set_idx)
                    IW'(1):  r_aruser  <= set_data;
                    IW'(2):  r_arcache <= set_data;
                    IW'(3):  r_awuser  <= set_data;
                    IW'(4):  r_awcache <= set_data;
                    IW'(9):  r_mask    <= set_data[NB-1:0];
                    default: ;
                endcase
            end

            r_en         <= w_en_next;
            r_status     <= w_status_next;
            r_cnt        <= w_cnt_next;
            r_soft_reset <= (w_cnt_next != '0);
            r_irq        <= |(r_status & r_mask);
        end
    end

    assign get_data   = r_get_data;
    assign get_ack    = r_get_ack;
    assign soft_reset = r_soft_reset;
    assign irq        = r_irq;
    assign aruser     = r_aruser;
    assign arcache    = r_arcache;
    assign awuser     = r_awuser;
    assign awcache    = r_awcache;
    assign s2h_en     = r_en[NS-1:0];
    assign h2s_en     = r_en[NB-1:NS];

endmodule

// File: tb/tb_stream_settings_bank.sv
module tb_stream_settings_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] set_data, set_addr, get_addr;
    logic        set_stb, get_stb;
    logic [31:0] get_data;
    logic        get_ack;
    logic [1:0]  s2h_done, h2s_done;
    logic        soft_reset;
    logic [31:0] aruser, arcache, awuser, awcache;
    logic [1:0]  s2h_en, h2s_en;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    stream_settings_bank dut (
        .clk(clk), .rst_n(rst_n),
        .set_data(set_data), .set_stb(set_stb), .set_addr(set_addr),
        .get_stb(get_stb), .get_addr(get_addr),
        .get_data(get_data), .get_ack(get_ack),
        .s2h_done(s2h_done), .h2s_done(h2s_done),
        .soft_reset(soft_reset),
        .aruser(aruser), .arcache(arcache), .awuser(awuser), .awcache(awcache),
        .s2h_en(s2h_en), .h2s_en(h2s_en), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: state after each edge, in plain integer terms.
    logic [31:0] m_side [1:4];
    int          m_en, m_status, m_mask, m_left;
    bit          m_irq, m_ack;
    logic [31:0] m_data;

    function automatic logic [31:0] model_read(int idx);
        case (idx)
            0:       return 32'hace0ba54;
            1, 2, 3, 4: return m_side[idx];
            5, 6:    return 32'd2;
            7:       return 32'(m_en);
            8:       return 32'(m_status);
            9:       return 32'(m_mask);
            10:      return (m_left > 0) ? 32'd1 : 32'd0;
            default: return 32'h01234567;
        endcase
    endfunction

    task automatic model_update();
        int  sidx, gidx, old_left;
        bit  wr0, busy;
        if (!rst_n) begin
            for (int i = 1; i <= 4; i++) m_side[i] = 0;
            m_en = 0; m_status = 0; m_mask = 0; m_left = 0;
            m_irq = 0; m_ack = 0; m_data = 0;
            return;
        end
        sidx = int'(set_addr[11:2]);
        gidx = int'(get_addr[11:2]);
        if (get_stb) m_data = model_read(gidx);
        m_ack = get_stb;
        m_irq = (m_status & m_mask) != 0;
        old_left = m_left;
        wr0  = set_stb && sidx == 0;
        busy = (old_left > 0) || wr0;
        if (set_stb && sidx >= 1 && sidx <= 4) m_side[sidx] = set_data;
        if (set_stb && sidx == 9) m_mask = int'(set_data) & 15;
        if (busy) begin
            m_en = 0;
            m_status = 0;
        end else begin
            if (set_stb && sidx == 7) m_en = int'(set_data) & 15;
            if (set_stb && sidx == 8) m_status = m_status & ~(int'(set_data) & 15);
            m_status = m_status | int'({h2s_done, s2h_done});
        end
        m_left = wr0 ? 16 : (old_left > 0 ? old_left - 1 : 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle();
        set_stb = 0; set_addr = 0; set_data = 0;
        get_stb = 0; get_addr = 0;
        s2h_done = 0; h2s_done = 0;
    endtask

    typedef struct {
        logic        set_stb;
        logic [31:0] set_addr;
        logic [31:0] set_data;
        logic        get_stb;
        logic [31:0] get_addr;
        logic [1:0]  s2h, h2s;
        logic        exp_ack;
        logic [31:0] exp_data;
        logic        exp_irq;
        logic [3:0]  exp_en;
        logic [31:0] exp_aruser;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic ss, input logic [31:0] sa, input logic [31:0] sd,
                        input logic gs, input logic [31:0] ga,
                        input logic [1:0] s2h, input logic [1:0] h2s,
                        input logic ea, input logic [31:0] ed, input logic ei,
                        input logic [3:0] ee, input logic [31:0] eu);
        vec_t v;
        v.set_stb = ss; v.set_addr = sa; v.set_data = sd;
        v.get_stb = gs; v.get_addr = ga; v.s2h = s2h; v.h2s = h2s;
        v.exp_ack = ea; v.exp_data = ed; v.exp_irq = ei; v.exp_en = ee; v.exp_aruser = eu;
        vecs.push_back(v);
    endtask

    task automatic sr_pulse(input int retrig, output int len);
        len = 0;
        idle();
        set_stb = 1; set_addr = 0; set_data = $urandom;
        step();
        if (soft_reset) len++;
        chk("en_cleared_at_sr", 32'({h2s_en, s2h_en}), 0);
        for (int k = 1; k < 60; k++) begin
            idle();
            if (k == retrig) begin set_stb = 1; set_addr = 32'h0; end
            if (k == 3) begin s2h_done = 2'b11; h2s_done = 2'b11; end
            if (k == 4) begin set_stb = 1; set_addr = 32'h1C; set_data = 32'hF; end
            if (k == 5) begin get_stb = 1; get_addr = 32'h28; end
            if (k == 6) begin get_stb = 1; get_addr = 32'h1C; end
            step();
            if (soft_reset) len++;
            if (k == 5) chk("sr_busy_read", get_data, 32'd1);
            if (k == 6) chk("en_read_during_sr", get_data, 32'd0);
        end
        idle();
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        idle();
        get_stb = 1; get_addr = addr;
        step();
        chk({name, "_ack"}, 32'(get_ack), 32'd1);
        chk(name, get_data, exp);
        idle();
    endtask

    initial begin
        int len;
        idle();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        chk("rst_soft_reset", 32'(soft_reset), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ack", 32'(get_ack), 0);
        chk("rst_data", get_data, 0);
        chk("rst_en", 32'({h2s_en, s2h_en}), 0);
        chk("rst_side", aruser | arcache | awuser | awcache, 0);

        //   ss sa            sd            gs ga       s2h   h2s   ack data          irq en    aruser
        addv(0, 32'h0,  32'h0,        1, 32'h00, 2'b00, 2'b00, 1, 32'hace0ba54, 0, 4'h0, 32'h0);
        addv(0, 32'h0,  32'h0,        1, 32'h14, 2'b00, 2'b00, 1, 32'd2,        0, 4'h0, 32'h0);
        addv(0, 32'h0,  32'h0,        1, 32'h18, 2'b00, 2'b00, 1, 32'd2,        0, 4'h0, 32'h0);
        addv(0, 32'h0,  32'h0,        1, 32'h2C, 2'b00, 2'b00, 1, 32'h01234567, 0, 4'h0, 32'h0);
        addv(0, 32'h0,  32'h0,        0, 32'h00, 2'b00, 2'b00, 0, 32'h01234567, 0, 4'h0, 32'h0);
        addv(1, 32'h04, 32'hA5,       1, 32'h04, 2'b00, 2'b00, 1, 32'h0,        0, 4'h0, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h04, 2'b00, 2'b00, 1, 32'hA5,       0, 4'h0, 32'hA5);
        addv(1, 32'h24, 32'h1,        0, 32'h00, 2'b00, 2'b00, 0, 32'hA5,       0, 4'h0, 32'hA5);
        addv(0, 32'h0,  32'h0,        0, 32'h00, 2'b01, 2'b00, 0, 32'hA5,       0, 4'h0, 32'hA5);
        addv(0, 32'h0,  32'h0,        0, 32'h00, 2'b00, 2'b00, 0, 32'hA5,       1, 4'h0, 32'hA5);
        addv(1, 32'h20, 32'h1,        0, 32'h00, 2'b01, 2'b00, 0, 32'hA5,       1, 4'h0, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h20, 2'b00, 2'b00, 1, 32'h1,        1, 4'h0, 32'hA5);
        addv(1, 32'h20, 32'h1,        0, 32'h00, 2'b00, 2'b00, 0, 32'h1,        1, 4'h0, 32'hA5);
        addv(0, 32'h0,  32'h0,        0, 32'h00, 2'b00, 2'b00, 0, 32'h1,        0, 4'h0, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h20, 2'b00, 2'b00, 1, 32'h0,        0, 4'h0, 32'hA5);
        addv(1, 32'h1C, 32'hF,        0, 32'h00, 2'b00, 2'b00, 0, 32'h0,        0, 4'hF, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h1C, 2'b00, 2'b00, 1, 32'hF,        0, 4'hF, 32'hA5);
        addv(0, 32'h0,  32'h0,        0, 32'h00, 2'b00, 2'b10, 0, 32'hF,        0, 4'hF, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h20, 2'b00, 2'b00, 1, 32'h8,        0, 4'hF, 32'hA5);
        addv(1, 32'h24, 32'hFFFFFFFF, 0, 32'h00, 2'b00, 2'b00, 0, 32'h8,        0, 4'hF, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h24, 2'b00, 2'b00, 1, 32'hF,        1, 4'hF, 32'hA5);
        addv(1, 32'h14, 32'h55,       0, 32'h00, 2'b00, 2'b00, 0, 32'hF,        1, 4'hF, 32'hA5);
        addv(0, 32'h0,  32'h0,        1, 32'h14, 2'b00, 2'b00, 1, 32'd2,        1, 4'hF, 32'hA5);

        foreach (vecs[i]) begin
            set_stb = vecs[i].set_stb; set_addr = vecs[i].set_addr; set_data = vecs[i].set_data;
            get_stb = vecs[i].get_stb; get_addr = vecs[i].get_addr;
            s2h_done = vecs[i].s2h; h2s_done = vecs[i].h2s;
            step();
            chk($sformatf("vec%0d_ack", i), 32'(get_ack), 32'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_data", i), get_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            chk($sformatf("vec%0d_en", i), 32'({h2s_en, s2h_en}), 32'(vecs[i].exp_en));
            chk($sformatf("vec%0d_aruser", i), aruser, vecs[i].exp_aruser);
            chk($sformatf("vec%0d_sr", i), 32'(soft_reset), 0);
        end
        idle();

        // Single soft-reset pulse, then a retriggered one.
        sr_pulse(0, len);
        chk("sr_len_single", 32'(len), 32'd16);
        read_chk("sr_idle_read", 32'h28, 32'd0);
        read_chk("en_after_sr", 32'h1C, 32'd0);
        read_chk("status_after_sr", 32'h20, 32'd0);
        read_chk("mask_kept", 32'h24, 32'hF);
        read_chk("aruser_kept", 32'h04, 32'hA5);
        sr_pulse(10, len);
        chk("sr_len_retrig", 32'(len), 32'd26);

        // rst_n during an active soft reset with a read and a write in flight.
        idle();
        set_stb = 1; set_addr = 32'h0;
        step();
        idle();
        set_stb = 1; set_addr = 32'h24; set_data = 32'h3;
        step();
        idle();
        set_stb = 1; set_addr = 32'h04; set_data = 32'h77;
        get_stb = 1; get_addr = 32'h04;
        rst_n = 0;
        step();
        chk("rstmid_sr", 32'(soft_reset), 0);
        chk("rstmid_ack", 32'(get_ack), 0);
        chk("rstmid_data", get_data, 0);
        chk("rstmid_irq", 32'(irq), 0);
        chk("rstmid_aruser", aruser, 0);
        rst_n = 1;
        idle();
        read_chk("rstmid_mask", 32'h24, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            int sidx, gidx;
            sidx = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 12);
            gidx = $urandom_range(0, 12);
            set_stb  = ($urandom_range(0, 2) == 0);
            set_addr = ($urandom & 32'hFFFFF000) | 32'(sidx << 2) | ($urandom & 32'h3);
            set_data = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 15);
            get_stb  = ($urandom_range(0, 1) == 0);
            get_addr = ($urandom & 32'hFFFFF000) | 32'(gidx << 2) | ($urandom & 32'h3);
            s2h_done = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            h2s_done = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
            chk("rnd_ack", 32'(get_ack), 32'(m_ack));
            chk("rnd_data", get_data, m_data);
            chk("rnd_sr", 32'(soft_reset), (m_left > 0) ? 32'd1 : 32'd0);
            chk("rnd_irq", 32'(irq), 32'(m_irq));
            chk("rnd_en", 32'({h2s_en, s2h_en}), 32'(m_en));
            chk("rnd_aruser", aruser, m_side[1]);
            chk("rnd_arcache", arcache, m_side[2]);
            chk("rnd_awuser", awuser, m_side[3]);
            chk("rnd_awcache", awcache, m_side[4]);
        end
        rst_n = 1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
